prefetch_queue: RTL

Instruction prefetch unit that sits directly upstream of the fetch/IR-load stage. It issues sequential word fetches to instruction memory over a req/ack handshake and buffers the returned words with their addresses in a small FIFO. The fetch stage pops one entry per IR load. A branch redirect flushes the queue and restarts fetching at a new PC, discarding any fetch still in flight.

---
 rtl/prefetch_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// Sequential instruction prefetcher: fetches words from imem and queues {pc, word} for the IR-load stage.
// Latency: a word acked in REQ is written on that edge and is visible at the head (ir_valid) right after it.
// Backpressure: a fetch is issued only if its word is guaranteed a slot; ir_ready pops the head, redirect flushes.
module prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_ack,
    input  logic [31:0]                  imem_rdata,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         ir_valid,
    output logic [31:0]                  ir_data,
    output logic [31:0]                  ir_pc,
    input  logic                         ir_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [31:0]     fetch_pc;
    logic [31:0]     addr_hold;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_nxt;
    logic [31:0]     mem_data [DEPTH];
    logic [31:0]     mem_pc   [DEPTH];

    logic            pop;
    logic            push;
    logic            space;
    logic [CW-1:0]   next_count;
    logic [31:0]     redir_pc;
    logic [31:0]     seq_pc;

    // Handshake decode; redirect wins over both pop and push.
    always_comb begin
        pop        = ir_valid & ir_ready & ~redirect;
        push       = (state == REQ) & imem_ack & ~redirect;
        next_count = count + CW'(push) - CW'(pop);
        space      = (next_count < CW'(DEPTH));
        redir_pc   = redirect_pc & 32'hFFFF_FFFC;
        seq_pc     = addr_hold + 32'd4;
        rd_nxt     = rd_ptr + 1'b1;
    end

    // Request is a pure decode of the state flops, so ack/ready never reach it combinationally.
    assign imem_req  = (state == REQ) || (state == DISCARD);
    assign imem_addr = addr_hold;
    assign ir_valid  = (count != '0);

    // Fetch FSM: addr_hold is loaded only on entry to REQ and stays put while a request is outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            addr_hold <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc  <= redir_pc;
                        addr_hold <= redir_pc;
                        state     <= REQ;
                    end else if (space) begin
                        addr_hold <= fetch_pc;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        fetch_pc <= redir_pc;
                        if (imem_ack) begin
                            // Returning word belongs to the old stream; drop it and restart.
                            addr_hold <= redir_pc;
                            state     <= REQ;
                        end else begin
                            // Old request must still complete on the bus before the new one.
                            state <= DISCARD;
                        end
                    end else if (imem_ack) begin
                        fetch_pc <= seq_pc;
                        if (space) begin
                            addr_hold <= seq_pc;
                            state     <= REQ;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= redir_pc;
                        if (imem_ack) begin
                            addr_hold <= redir_pc;
                            state     <= REQ;
                        end
                    end else if (imem_ack) begin
                        addr_hold <= fetch_pc;
                        state     <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Entry storage; never written on a redirect cycle, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= addr_hold;
        end
    end

    // Occupancy, pointers and the registered head; the head bypasses storage when the queue is (about to be) empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ir_data <= 32'd0;
            ir_pc   <= 32'd0;
        end else if (redirect) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            count <= next_count;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_nxt;
                if (count > CW'(1)) begin
                    ir_data <= mem_data[rd_nxt];
                    ir_pc   <= mem_pc[rd_nxt];
                end else if (push) begin
                    ir_data <= imem_rdata;
                    ir_pc   <= addr_hold;
                end
            end else if ((count == '0) && push) begin
                ir_data <= imem_rdata;
                ir_pc   <= addr_hold;
            end
        end
    end

endmodule
